rds_msg_arbiter: RTL and testbench
==================================

// Module: rds_msg_arbiter
// PURPOSE
//  Shares the single-port RDS message BRAM between the real-time RDS reader
//  (rds mixer, bit-serial, low rate) and a host writer (CPU/UART loader).
//  The RAM is double-buffered as two pages. The host fills the back page, then
//  requests a commit. The pages swap only at a message boundary (reader fetches
//  address 0), so the on-air RDS group sequence is never torn.
// PARAMETERS
//  ADDR_W      9  message address width per page (RAM address = ADDR_W+1)
//  DATA_W      8  message byte width
//  FIFO_LOG2   2  log2 of host write FIFO depth (depth 4)
// PORTS
//  clk          in   1         system clock (25 MHz domain)
//  rst_n        in   1         asynchronous active-low reset
//  rd_req       in   1         reader read request, 1-cycle pulse
//  rd_addr      in   ADDR_W    reader byte address, valid with rd_req
//  rd_data      out  DATA_W    read byte, held until next rd_valid
//  rd_valid     out  1         1-cycle pulse, rd_data valid
//  wr_valid     in   1         host write request
//  wr_ready     out  1         FIFO can accept write (valid&ready = accepted)
//  wr_addr      in   ADDR_W    host byte address (always into back page)
//  wr_data      in   DATA_W    host byte
//  commit       in   1         1-cycle pulse: publish back page
//  commit_pend  out  1         commit requested, swap not yet done
//  swap         out  1         1-cycle pulse on the cycle pages swap
//  active_page  out  1         page the reader currently sees
//  ram_addr     out  ADDR_W+1  {page, addr} to BRAM
//  ram_we       out  1         BRAM write enable
//  ram_wdata    out  DATA_W    BRAM write data
//  ram_rdata    in   DATA_W    BRAM read data, 1-cycle latency
// BEHAVIOUR
//  Reset (async assert, sync release): active_page=0, FIFO empty,
//   commit_pend=0, rd_valid=0, rd_data=0, swap=0, ram_we=0, ram_addr=0,
//   ram_wdata=0, wr_ready=1 after release.
//  Registered outputs: ram_addr, ram_we, ram_wdata are registered. RAM cycle
//   owner is decided each cycle.
//   1) rd_req=1: read {active_page', rd_addr}, ram_we=0. Reader has absolute priority.
//   2) else FIFO non-empty: pop one entry, write {~active_page, addr}.
//   3) else idle: ram_we=0, ram_addr holds its value.
//  Read latency: rd_req at cycle t -> RAM addressed t+1 -> rd_valid=1, rd_data
//   captured from ram_rdata at t+2. Back-to-back rd_req are pipelined: each
//   gives its own rd_valid 2 cycles later, in order.
//  FIFO: depth 2**FIFO_LOG2 with wrapping pointers and a count.
//   wr_ready = !full && !commit_pend.
//   Push and pop in the same cycle: count unchanged.
//   Full: wr_valid ignored, no overwrite.
//  Commit/swap:
//   commit sets commit_pend. A commit while pending is ignored.
//   Swap condition: commit_pend && FIFO empty && no write in flight && rd_req
//    && rd_addr==0.
//   On swap: active_page toggles in the same cycle; active_page' = new page,
//    and that addr-0 read uses the new page. swap=1 for 1 cycle, commit_pend
//    clears.
//   commit with no prior writes still swaps at the next boundary.
//   A rd_req with addr 0 while FIFO is not yet drained does not swap; the swap
//    waits for the next boundary.
//  Host write latency: bounded only by reader gaps. RDS reader rate (~1.2 kHz)
//   guarantees FIFO drain within a few cycles.
//  Reset mid-operation: FIFO contents and pending commit are discarded;
//   in-flight rd_valid is suppressed.
// TESTING
//  T1 reset: hold rst_n=0 -> all outputs 0; release -> wr_ready=1, page 0.
//  T2 read: rd_req, rd_addr=5, BRAM[{0,5}]=0x41 -> rd_valid at t+2,
//     rd_data=0x41.
//  T3 priority: FIFO holds 1 write and rd_req arrives the same cycle ->
//     read issued first, write to page 1 on the next cycle.
//  T4 full: 5 writes with no pop possible (rd_req held every cycle) ->
//     wr_ready=0 after 4, 5th stalls. Drop rd_req -> 4 writes in 4 cycles.
//  T5 swap: write 0x52 to addr 0, commit, rd_req addr 3 (no swap), then
//     rd_req addr 0 -> swap=1, active_page=1, rd_data=0x52.
//  T6 reset mid-commit: commit_pend=1 with 2 queued writes, pulse rst_n ->
//     FIFO empty, commit_pend=0, no swap follows.

Source files
------------

// File: rtl/rds_msg_arbiter.sv
// Purpose: shares the single-port RDS message BRAM between the RDS reader and a host writer, with two swappable pages.
// Latency: a read gives rd_valid 2 cycles after rd_req; a host write reaches the RAM 1 cycle after it is popped.
// Backpressure: wr_ready drops when the FIFO is full or a commit is pending; the reader never waits.
module rds_msg_arbiter #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 8,
  parameter int FIFO_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              commit_i,
  output logic              commit_pend_o,
  output logic              swap_o,
  output logic              active_page_o,
  output logic [ADDR_W:0]   ram_addr_o,
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0]   CNT_ONE  = 1;
  localparam logic [FIFO_LOG2:0]   CNT_FULL = DEPTH[FIFO_LOG2:0];
  localparam logic [FIFO_LOG2-1:0] PTR_ONE  = 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dat;
  } wr_ent_t;

  // Host write FIFO storage; contents are only meaningful below the count
  wr_ent_t                fifo_mem [DEPTH];
  logic [FIFO_LOG2-1:0]   wptr_q, wptr_d;
  logic [FIFO_LOG2-1:0]   rptr_q, rptr_d;
  logic [FIFO_LOG2:0]     cnt_q, cnt_d;

  logic                   commit_pend_q, commit_pend_d;
  logic                   page_q, page_d;
  logic                   swap_q;
  logic [ADDR_W:0]        ram_addr_q, ram_addr_d;
  logic                   ram_we_q, ram_we_d;
  logic [DATA_W-1:0]      ram_wdata_q, ram_wdata_d;
  logic                   rd_pipe_q;
  logic                   rd_valid_q;
  logic [DATA_W-1:0]      rd_hold_q;
  logic                   rst_done_q;

  logic                   fifo_full, fifo_empty;
  logic                   push, pop, swap_now;
  wr_ent_t                head;

  assign fifo_full  = (cnt_q == CNT_FULL);
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_mem[rptr_q];

  // wr_ready stays low until the first clock after reset release
  assign wr_ready_o = rst_done_q && !fifo_full && !commit_pend_q;
  assign push       = wr_valid_i && wr_ready_o;
  // The reader owns the RAM whenever it asks; the FIFO only drains in reader gaps
  assign pop        = !rd_req_i && !fifo_empty;
  // Swap only at a message start, with every host byte already in the RAM
  assign swap_now   = commit_pend_q && fifo_empty && !ram_we_q &&
                      rd_req_i && (rd_addr_i == '0);
  // The addr-0 read that triggers a swap already sees the new page
  assign page_d     = page_q ^ swap_now;

  // Next-state for FIFO pointers, count, commit flag and the RAM port
  always_comb begin
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    cnt_d         = cnt_q;
    commit_pend_d = commit_pend_q;
    ram_addr_d    = ram_addr_q;
    ram_we_d      = 1'b0;
    ram_wdata_d   = ram_wdata_q;

    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;
    if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
    else if (!push && pop) cnt_d = cnt_q - CNT_ONE;

    if (swap_now)      commit_pend_d = 1'b0;
    else if (commit_i) commit_pend_d = 1'b1;

    if (rd_req_i) begin
      ram_addr_d = {page_d, rd_addr_i};
    end else if (pop) begin
      ram_addr_d  = {~page_q, head.addr};
      ram_we_d    = 1'b1;
      ram_wdata_d = head.dat;
    end
  end

  // FIFO storage write, no reset needed since the count guards the contents
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= '{addr: wr_addr_i, dat: wr_data_i};
  end

  // Control state and registered RAM port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      cnt_q         <= '0;
      commit_pend_q <= 1'b0;
      page_q        <= 1'b0;
      swap_q        <= 1'b0;
      ram_addr_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_wdata_q   <= '0;
      rst_done_q    <= 1'b0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      cnt_q         <= cnt_d;
      commit_pend_q <= commit_pend_d;
      page_q        <= page_d;
      swap_q        <= swap_now;
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_wdata_q   <= ram_wdata_d;
      rst_done_q    <= 1'b1;
    end
  end

  // Read return pipeline: one stage for the RAM address, one for RAM latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      rd_pipe_q  <= rd_req_i;
      rd_valid_q <= rd_pipe_q;
      if (rd_valid_q) rd_hold_q <= ram_rdata_i;
    end
  end

  // RAM data passes straight through on the valid cycle, then is held
  assign rd_data_o     = rd_valid_q ? ram_rdata_i : rd_hold_q;
  assign rd_valid_o    = rd_valid_q;
  assign commit_pend_o = commit_pend_q;
  assign swap_o        = swap_q;
  assign active_page_o = page_q;
  assign ram_addr_o    = ram_addr_q;
  assign ram_we_o      = ram_we_q;
  assign ram_wdata_o   = ram_wdata_q;

endmodule

// File: tb/tb_rds_msg_arbiter.sv
// Purpose: self-checking bench for rds_msg_arbiter with a behavioural BRAM and a read scoreboard.
// Latency: reads are expected exactly 2 cycles after issue; write timing is checked on the RAM port.
// Backpressure: exercises FIFO full, commit-pending stall and reader-priority starvation.
module tb_rds_msg_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_req = 1'b0;
  logic [8:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [8:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       commit = 1'b0;
  logic       commit_pend;
  logic       swap;
  logic       active_page;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] dat;
    int         due;
  } sb_ent_t;
  sb_ent_t sb[$];

  typedef struct {
    logic [8:0] addr;
    logic [7:0] exp;
    int         gap;
  } rd_vec_t;
  rd_vec_t tbl[8];

  rds_msg_arbiter #(.ADDR_W(9), .DATA_W(8), .FIFO_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .commit_i(commit), .commit_pend_o(commit_pend), .swap_o(swap), .active_page_o(active_page),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural BRAM, read-first, 1-cycle read latency; page 0 = a^A5, page 1 = a^3C
  logic [7:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] a;
      a = 10'(i);
      mem[i] = a[9] ? (a[7:0] ^ 8'h3C) : (a[7:0] ^ 8'hA5);
    end
    mem[5] = 8'h41;
    ram_rdata = '0;
    forever begin
      @(posedge clk);
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every rd_valid must match the oldest outstanding read, on time
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_unexpected: got rd_valid=1 expected 0 at cycle %0d", cyc);
      end else begin
        sb_ent_t e;
        e = sb.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e.dat));
        chk("rd_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; a read pushes its expected byte and due cycle
  task automatic drive(input logic rr, input logic [8:0] ra, input logic [7:0] re,
                       input logic wv, input logic [8:0] wa, input logic [7:0] wd,
                       input logic cm);
    rd_req   = rr;
    rd_addr  = ra;
    wr_valid = wv;
    wr_addr  = wa;
    wr_data  = wd;
    commit   = cm;
    if (rr) sb.push_back('{dat: re, due: cyc + 2});
    step();
    rd_req   = 1'b0;
    wr_valid = 1'b0;
    commit   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_rd_data"}, 32'(rd_data), 0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 0);
    chk({tag, "_commit_pend"}, 32'(commit_pend), 0);
    chk({tag, "_swap"}, 32'(swap), 0);
    chk({tag, "_active_page"}, 32'(active_page), 0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
    chk({tag, "_ram_we"}, 32'(ram_we), 0);
    chk({tag, "_ram_wdata"}, 32'(ram_wdata), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{addr: 9'd5,   exp: 8'h41, gap: 0};
    tbl[1] = '{addr: 9'd0,   exp: 8'hA5, gap: 0};
    tbl[2] = '{addr: 9'd1,   exp: 8'hA4, gap: 2};
    tbl[3] = '{addr: 9'd100, exp: 8'hC1, gap: 0};
    tbl[4] = '{addr: 9'd511, exp: 8'h5A, gap: 1};
    tbl[5] = '{addr: 9'd256, exp: 8'hA5, gap: 0};
    tbl[6] = '{addr: 9'd7,   exp: 8'hA2, gap: 3};
    tbl[7] = '{addr: 9'd5,   exp: 8'h41, gap: 0};

    // Reset: everything low while held, wr_ready up after release
    step();
    step();
    chk_reset_outputs("t1");
    rst_n = 1'b1;
    step();
    chk("t1_wr_ready", 32'(wr_ready), 1);
    chk("t1_active_page", 32'(active_page), 0);

    // Reads from page 0, back-to-back and with gaps
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i].addr, tbl[i].exp, 1'b0, '0, '0, 1'b0);
      chk("rd_ram_addr", 32'(ram_addr), 32'({1'b0, tbl[i].addr}));
      chk("rd_ram_we", 32'(ram_we), 0);
      idle(tbl[i].gap);
    end

    // Priority: queued write waits behind a read, then goes to page 1
    drive(1'b0, '0, '0, 1'b1, 9'd9, 8'h77, 1'b0);
    drive(1'b1, 9'd2, 8'hA7, 1'b0, '0, '0, 1'b0);
    chk("t3_read_addr", 32'(ram_addr), 32'h002);
    chk("t3_read_we", 32'(ram_we), 0);
    idle(1);
    chk("t3_write_we", 32'(ram_we), 1);
    chk("t3_write_addr", 32'(ram_addr), 32'h209);
    chk("t3_write_data", 32'(ram_wdata), 32'h77);

    // FIFO full while the reader hogs the RAM, then drain in 4 cycles
    for (int i = 0; i < 6; i++) begin
      int k;
      k = (i < 4) ? i : 4;
      chk("t4_wr_ready", 32'(wr_ready), (i < 4) ? 1 : 0);
      drive(1'b1, 9'd20, 8'hB1, 1'b1, 9'(30 + k), 8'(8'hC0 + k), 1'b0);
      chk("t4_no_write", 32'(ram_we), 0);
    end
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("t4_drain_we", 32'(ram_we), 1);
      chk("t4_drain_addr", 32'(ram_addr), 32'(10'h200 + 10'(30 + i)));
      chk("t4_drain_data", 32'(ram_wdata), 32'(8'hC0 + i));
    end
    idle(1);
    chk("t4_drained_we", 32'(ram_we), 0);

    // Swap waits for the addr-0 boundary, which reads the new page
    drive(1'b0, '0, '0, 1'b1, 9'd0, 8'h52, 1'b0);
    idle(1);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    chk("t5_pend", 32'(commit_pend), 1);
    chk("t5_wr_ready", 32'(wr_ready), 0);
    drive(1'b1, 9'd3, 8'hA6, 1'b0, '0, '0, 1'b0);
    chk("t5_no_swap", 32'(swap), 0);
    chk("t5_page_old", 32'(active_page), 0);
    drive(1'b1, 9'd0, 8'h52, 1'b0, '0, '0, 1'b0);
    chk("t5_swap", 32'(swap), 1);
    chk("t5_page_new", 32'(active_page), 1);
    chk("t5_pend_clr", 32'(commit_pend), 0);
    chk("t5_swap_addr", 32'(ram_addr), 32'h200);
    idle(1);
    chk("t5_swap_pulse", 32'(swap), 0);
    drive(1'b1, 9'd30, 8'hC0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 9'd9,  8'h77, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 9'd4,  8'h38, 1'b0, '0, '0, 1'b0);

    // Boundary while the FIFO still holds a write: no swap until drained
    drive(1'b1, 9'd4, 8'h38, 1'b1, 9'd0, 8'h99, 1'b0);
    drive(1'b1, 9'd4, 8'h38, 1'b0, '0, '0, 1'b1);
    drive(1'b1, 9'd0, 8'h52, 1'b0, '0, '0, 1'b0);
    chk("t5b_no_swap", 32'(swap), 0);
    chk("t5b_page", 32'(active_page), 1);
    chk("t5b_pend", 32'(commit_pend), 1);
    idle(1);
    chk("t5b_write_we", 32'(ram_we), 1);
    chk("t5b_write_addr", 32'(ram_addr), 32'h000);
    idle(1);
    drive(1'b1, 9'd0, 8'h99, 1'b0, '0, '0, 1'b0);
    chk("t5b_swap", 32'(swap), 1);
    chk("t5b_page_back", 32'(active_page), 0);

    // Reset with a pending commit and queued writes discards everything
    drive(1'b1, 9'd1, 8'hA4, 1'b1, 9'd40, 8'hD0, 1'b0);
    drive(1'b1, 9'd1, 8'hA4, 1'b1, 9'd41, 8'hD1, 1'b0);
    drive(1'b1, 9'd1, 8'hA4, 1'b0, '0, '0, 1'b1);
    chk("t6_pend", 32'(commit_pend), 1);
    rst_n = 1'b0;
    sb.delete();
    step();
    step();
    chk_reset_outputs("t6");
    rst_n = 1'b1;
    step();
    chk("t6_pend_after", 32'(commit_pend), 0);
    chk("t6_wr_ready", 32'(wr_ready), 1);
    chk("t6_page", 32'(active_page), 0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("t6_fifo_empty", 32'(ram_we), 0);
    end
    drive(1'b1, 9'd0, 8'h99, 1'b0, '0, '0, 1'b0);
    chk("t6_no_swap", 32'(swap), 0);
    chk("t6_page_kept", 32'(active_page), 0);

    // Let outstanding reads return, bounded
    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    chk("sb_drained", 32'(sb.size()), 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
